fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning PC/address width.
REQ-002 SHALL have parameter INSTR_WIDTH, default 32, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 64'h0, meaning first fetch address after reset.
REQ-004 SHALL have port i_clk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL have port i_arst  in  1  reset, asynchronous and active-low: asserted at 0, released at 1.
REQ-006 SHALL have port i_ready  in  1  decode accepts the head entry this cycle (low = stall).
REQ-007 SHALL have port i_flush  in  1  redirect from execute; discards all in-flight fetches.
REQ-008 SHALL have port i_redirect_pc  in  ADDR_WIDTH  new PC on flush.
REQ-009 SHALL have port o_imem_req  out  1  instruction-memory request valid.
REQ-010 SHALL have port o_imem_addr  out  ADDR_WIDTH  request address (current PC).
REQ-011 SHALL have port i_imem_ack  in  1  request accepted and data valid, same cycle.
REQ-012 SHALL have port i_imem_data  in  INSTR_WIDTH  fetched instruction.
REQ-013 SHALL have ports i_pred_taken 1, i_pred_target ADDR_WIDTH, i_btb_way 2  in  BTB lookup of o_imem_addr, combinational.
REQ-014 SHALL have ports o_valid 1, o_instruction INSTR_WIDTH, o_pc, o_pc_plus4, o_pc_target_addr_pred ADDR_WIDTH, o_btb_way 2, o_branch_pred_taken 1, o_log_trace 1  out  head queue entry to decode.

Function
REQ-015 SHALL allow at most one outstanding memory request; o_imem_req/o_imem_addr held stable until i_imem_ack or i_flush.
REQ-016 SHALL raise o_imem_req only when queue occupancy plus outstanding requests < 2.
REQ-017 SHALL on ack push {data, pc, pc+4, pred target, btb way, pred taken, log_trace=1} into a 2-entry FIFO and advance PC to i_pred_target if i_pred_taken else PC+4 (ADDR_WIDTH wrap-around).
REQ-018 SHALL drive o_valid high whenever FIFO non-empty; entry pops on o_valid & i_ready; outputs are registered FIFO head, zero when empty.
REQ-019 SHALL support push and pop in the same cycle with queue full (occupancy unchanged).
REQ-020 SHALL implement FSM: FETCH (issue/hold request), DROP (flush occurred with request outstanding and ack not seen; hold o_imem_req low, discard next ack, then FETCH).
REQ-021 SHALL on i_flush: empty FIFO, o_valid low next cycle, PC <= i_redirect_pc; flush takes priority over same-cycle ack, push and pop (ack data discarded, no DROP entered).
REQ-022 SHALL fetch i_redirect_pc at earliest the cycle after flush (FETCH) or the cycle after the discarded ack (DROP).
REQ-023 SHALL give minimum latency of one cycle from ack to o_valid.

Reset
REQ-024 SHALL on i_arst=0 asynchronously set PC=RESET_PC, FIFO empty, FSM=FETCH, all outputs 0 except o_imem_addr=RESET_PC.
REQ-025 SHALL ignore any ack arriving while reset is asserted; reset mid-request drops it.
REQ-026 SHALL raise o_imem_req on the first rising edge after reset release.

Structure
REQ-027 SHALL place FSM state enum and RESET_PC default in the shared core package.
REQ-028 SHALL instantiate one sub-module fetch_queue (2-entry FIFO, parameterised payload width).

Verification
REQ-029 Reset release, ack every cycle, i_ready=1, no prediction -> fetches 0x0,0x4,0x8; o_valid from cycle 2; o_pc_plus4 = o_pc+4.
REQ-030 i_ready=0 for 5 cycles with ack always 1 -> exactly 2 entries queued, o_imem_req low while full, no entry lost or duplicated on release.
REQ-031 Fetch at 0x10 with i_pred_taken=1, target 0x80 -> next o_imem_addr=0x80; entry carries o_branch_pred_taken=1, o_pc_target_addr_pred=0x80.
REQ-032 Flush to 0x200 while request at 0x14 outstanding, ack 2 cycles later -> FSM enters DROP, 0x14 data never reaches o_valid, next request address 0x200.
REQ-033 Flush and ack same cycle, queue full -> FIFO empty next cycle, ack data discarded, next request 0x200.
REQ-034 Drive i_arst=0 mid-request with 2 entries queued -> o_valid=0 and o_imem_addr=RESET_PC immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the fetch stage: FSM encoding and reset PC.
package fetch_stage_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DROP  = 1'b1
    } fetch_state_t;

    localparam logic [63:0] CORE_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO between instruction fetch and decode; payload width is generic.
module fetch_queue #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_data  = o_valid ? r_mem[r_rd] : '0;

    // Push is accepted when there is room, or when full but the head leaves this cycle.
    always_comb begin
        w_pop       = i_pop & o_valid;
        w_push      = i_push & (~o_full | w_pop);
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Storage, pointers and occupancy; flush empties the queue.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem request, BTB-steered PC, 2-entry queue to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned             ADDR_WIDTH  = 64,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = ADDR_WIDTH'(CORE_RESET_PC)
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_ready,
    input  logic                   i_flush,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_pc,
    output logic                   o_imem_req,
    output logic [ADDR_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_ack,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    input  logic                   i_pred_taken,
    input  logic [ADDR_WIDTH-1:0]  i_pred_target,
    input  logic [1:0]             i_btb_way,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]  o_pc_target_addr_pred,
    output logic [1:0]             o_btb_way,
    output logic                   o_branch_pred_taken,
    output logic                   o_log_trace
);

    localparam int unsigned PW = INSTR_WIDTH + 3 * ADDR_WIDTH + 4;

    fetch_state_t          r_state;
    fetch_state_t          w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic                  r_run;
    logic                  w_accept;
    logic                  w_full;
    logic [PW-1:0]         w_push_data;
    logic [PW-1:0]         w_head;

    assign w_pc_plus4  = r_pc + ADDR_WIDTH'(4);
    assign o_imem_addr = r_pc;
    assign w_push_data = {i_imem_data, r_pc, w_pc_plus4, i_pred_target,
                          i_btb_way, i_pred_taken, 1'b1};
    assign {o_instruction, o_pc, o_pc_plus4, o_pc_target_addr_pred,
            o_btb_way, o_branch_pred_taken, o_log_trace} = w_head;

    // State, PC and the one-shot run flag that holds the request off until after reset release.
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_run   <= 1'b1;
        end
    end

    // Request generation, ack acceptance and next state; flush overrides any same-cycle ack.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        o_imem_req  = r_run & (r_state == ST_FETCH) & ~w_full;
        w_accept    = o_imem_req & i_imem_ack & ~i_flush;
        if (i_flush) begin
            w_pc_nxt = i_redirect_pc;
            if (r_state == ST_FETCH) begin
                w_state_nxt = (o_imem_req && !i_imem_ack) ? ST_DROP : ST_FETCH;
            end else begin
                w_state_nxt = i_imem_ack ? ST_FETCH : ST_DROP;
            end
        end else if (r_state == ST_DROP) begin
            if (i_imem_ack) begin
                w_state_nxt = ST_FETCH;
            end
        end else if (w_accept) begin
            w_pc_nxt = i_pred_taken ? i_pred_target : w_pc_plus4;
        end
    end

    fetch_queue #(
        .WIDTH(PW)
    ) u_queue (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_flush (i_flush),
        .i_push  (w_accept),
        .i_data  (w_push_data),
        .i_pop   (i_ready),
        .o_valid (o_valid),
        .o_full  (w_full),
        .o_data  (w_head)
    );

endmodule
